// File: rtl/pwr_led_pkg.sv
// pwr_led_pkg: shared FSM state type and width helpers for the front-panel fault LED logic.
//   Contents: state_e (IDLE/PICK/ON/OFF/GAP), MAX_FAULTS, CODE_W, max3() width helper.
package pwr_led_pkg;
   typedef enum logic [2:0] {IDLE, PICK, ON, OFF, GAP} state_e;
   localparam int MAX_FAULTS = 15;
   localparam int CODE_W     = $clog2(MAX_FAULTS + 1);
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: CLK_PER_MS prescaler producing a 1-cycle millisecond tick.
//   sys_clk   in  system clock
//   reset_n   in  asynchronous active-low reset
//   restart_i in  synchronous restart; count is 0 in the cycle after it is seen
//   ms_tick_o out high for one cycle every CLK_PER_MS cycles
module ms_tick_gen #(
   parameter int CLK_PER_MS = 25000
) (
   input  logic sys_clk,
   input  logic reset_n,
   input  logic restart_i,
   output logic ms_tick_o
);
   localparam int CW = $clog2(CLK_PER_MS + 1);
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   assign ms_tick_o = (cnt_q == LAST);
   assign cnt_d     = (restart_i || ms_tick_o) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
endmodule

// File: rtl/pwr_fault_blink_sched.sv
// pwr_fault_blink_sched: sticky power-fault latches, round-robin blink-code player and 1 Hz LED clock.
//   sys_clk          in  system clock
//   reset_n          in  asynchronous active-low reset
//   fault_in         in  level fault sources, synchronous to sys_clk
//   fault_clr        in  1-cycle pulse clearing all latches (wins over fault_in)
//   onehz_clk        out free-running square wave, half-period HZ_HALF_MS ms
//   power_fault      out registered OR of latched faults
//   fault_blink_code out blink pattern, 1 = LED on
//   cur_code         out code being played (index+1), 0 when idle
//   fault_latched    out sticky fault latches
module pwr_fault_blink_sched
   import pwr_led_pkg::*;
#(
   parameter int NUM_FAULTS = 8,
   parameter int CLK_PER_MS = 25000,
   parameter int ON_MS      = 250,
   parameter int OFF_MS     = 250,
   parameter int GAP_MS     = 1500,
   parameter int HZ_HALF_MS = 500
) (
   input  logic                  sys_clk,
   input  logic                  reset_n,
   input  logic [NUM_FAULTS-1:0] fault_in,
   input  logic                  fault_clr,
   output logic                  onehz_clk,
   output logic                  power_fault,
   output logic                  fault_blink_code,
   output logic [CODE_W-1:0]     cur_code,
   output logic [NUM_FAULTS-1:0] fault_latched
);
   localparam int TW = $clog2(max3(ON_MS, OFF_MS, GAP_MS) + 1);
   localparam int HW = $clog2(HZ_HALF_MS + 1);
   localparam logic [HW-1:0]     HZ_LAST  = HW'(HZ_HALF_MS - 1);
   localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(NUM_FAULTS - 1);
   localparam logic [CODE_W:0]   NF       = (CODE_W + 1)'(NUM_FAULTS);

   logic [NUM_FAULTS-1:0] latched_q, latched_d;
   logic                  pf_q;
   logic                  hz_tick, hz_q;
   logic [HW-1:0]         hz_cnt_q;
   logic                  ph_tick, ph_restart, ph_done;
   logic [TW-1:0]         ph_ms_q, ph_len;
   state_e                state_q;
   logic [CODE_W-1:0]     rr_q, pulse_q, code_q;
   logic                  blink_q;
   logic [CODE_W-1:0]     start_idx, off, pick_idx;
   logic [NUM_FAULTS-1:0] rot;
   logic [CODE_W:0]       sum;

   assign latched_d = fault_clr ? '0 : (latched_q | fault_in);

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         latched_q <= '0;
         pf_q      <= 1'b0;
      end else begin
         latched_q <= latched_d;
         pf_q      <= |latched_d;
      end
   end

   // onehz prescaler is never restarted so the WAIT/denied blink stays steady
   ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_hz_tick (
      .sys_clk  (sys_clk),
      .reset_n  (reset_n),
      .restart_i(1'b0),
      .ms_tick_o(hz_tick)
   );

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         hz_cnt_q <= '0;
         hz_q     <= 1'b0;
      end else if (hz_tick) begin
         hz_cnt_q <= (hz_cnt_q == HZ_LAST) ? '0 : hz_cnt_q + 1'b1;
         hz_q     <= (hz_cnt_q == HZ_LAST) ? ~hz_q : hz_q;
      end
   end

   // Restarting in IDLE/PICK and on every expiry zeroes the timer on the first cycle of each phase
   ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_ph_tick (
      .sys_clk  (sys_clk),
      .reset_n  (reset_n),
      .restart_i(ph_restart),
      .ms_tick_o(ph_tick)
   );

   assign ph_len     = (state_q == ON) ? TW'(ON_MS) : (state_q == OFF) ? TW'(OFF_MS) : TW'(GAP_MS);
   assign ph_done    = (state_q inside {ON, OFF, GAP}) && ph_tick && (ph_ms_q == ph_len - 1'b1);
   assign ph_restart = (state_q == IDLE) || (state_q == PICK) || ph_done;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n)        ph_ms_q <= '0;
      else if (ph_restart) ph_ms_q <= '0;
      else if (ph_tick)    ph_ms_q <= ph_ms_q + 1'b1;
   end

   // Rotate the latches so the search starts just above rr_q, then unrotate the hit
   assign start_idx = (rr_q == LAST_IDX) ? '0 : rr_q + 1'b1;
   assign rot       = NUM_FAULTS'({latched_q, latched_q} >> start_idx);
   always_comb begin
      off = '0;
      for (int k = NUM_FAULTS - 1; k >= 0; k--)
         if (rot[k]) off = CODE_W'(k);
   end
   assign sum      = {1'b0, start_idx} + {1'b0, off};
   assign pick_idx = (sum >= NF) ? CODE_W'(sum - NF) : sum[CODE_W-1:0];

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rr_q    <= LAST_IDX;
         pulse_q <= '0;
         code_q  <= '0;
         blink_q <= 1'b0;
      end else if (latched_q == '0) begin
         state_q <= IDLE;
         code_q  <= '0;
         blink_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: state_q <= PICK;
            PICK: begin
               rr_q    <= pick_idx;
               code_q  <= pick_idx + 1'b1;
               pulse_q <= pick_idx + 1'b1;
               state_q <= ON;
               blink_q <= 1'b1;
            end
            ON: if (ph_done) begin
               pulse_q <= pulse_q - 1'b1;
               state_q <= OFF;
               blink_q <= 1'b0;
            end
            OFF: if (ph_done) begin
               state_q <= (pulse_q == '0) ? GAP : ON;
               blink_q <= (pulse_q != '0);
            end
            GAP: if (ph_done) state_q <= PICK;
            default: begin
               state_q <= IDLE;
               blink_q <= 1'b0;
            end
         endcase
      end
   end

   assign onehz_clk        = hz_q;
   assign power_fault      = pf_q;
   assign fault_blink_code = blink_q;
   assign cur_code         = code_q;
   assign fault_latched    = latched_q;
endmodule
